// File: rtl/axi_ts_pkg.sv
// ---------------------------------------------------------------------------
// axi_ts_pkg
// Shared types and helpers for the external-trigger conditioning path.
//   edge_sel_e        : edge-select encoding driven by the register bank
//   ext_trig_state_e  : acceptance state machine encoding
//   SYNC_STAGES_MIN   : smallest legal synchroniser depth
//   edge_select()     : maps a rise/fall pair onto the selected edge hit
// ---------------------------------------------------------------------------
package axi_ts_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        BOTH = 2'd2,
        NONE = 2'd3
    } edge_sel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } ext_trig_state_e;

    function automatic logic edge_select(input logic [1:0] sel,
                                         input logic       rise,
                                         input logic       fall);
        logic hit;
        hit = 1'b0;
        case (edge_sel_e'(sel))
            RISE:    hit = rise;
            FALL:    hit = fall;
            BOTH:    hit = rise | fall;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/axi_ts_ext_trig_sync_filter.sv
// ---------------------------------------------------------------------------
// axi_ts_sync_filter
// Brings the raw trigger pin into the clk domain, rejects glitches shorter
// than cfg_filter_len + 1 cycles and produces registered edge strobes.
//   clk, rst        : clock, asynchronous active-high reset
//   trig_in         : raw asynchronous pin
//   cfg_filter_len  : extra stable cycles needed before a level change lands
//   filt            : filtered level
//   rise, fall      : one-cycle strobes, one cycle after filt changes
// ---------------------------------------------------------------------------
module axi_ts_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig_in,
    input  logic [FILTER_W-1:0] cfg_filter_len,
    output logic                filt,
    output logic                rise,
    output logic                fall
);
    import axi_ts_pkg::*;

    // A depth below the minimum would not be a real synchroniser.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    logic                r_filt;
    logic                r_filt_d;
    logic [FILTER_W-1:0] r_cnt;
    logic                r_rise;
    logic                r_fall;
    logic                w_s;

    assign w_s = r_sync[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], trig_in};
        end
    end

    // The counter measures how long the synchronised level has disagreed with
    // the accepted level; any return to agreement restarts the count.
    // ">=" keeps the filter from running past a length lowered mid-count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            if (w_s == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt >= cfg_filter_len) begin
                r_filt <= w_s;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + FILTER_W'(1);
            end
            r_filt_d <= r_filt;
            r_rise   <= r_filt & ~r_filt_d;
            r_fall   <= ~r_filt & r_filt_d;
        end
    end

    assign filt = r_filt;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/axi_ts_ext_trig.sv
// ---------------------------------------------------------------------------
// axi_ts_ext_trig
// Turns the external trigger pin into a single-cycle ext_trigger pulse and
// stamps every accepted trigger with the RTC time.
//   clk, rst            : clock, asynchronous active-high reset
//   trig_in             : raw asynchronous trigger pin
//   cfg_enable          : accept triggers when 1
//   cfg_edge            : 0 rise, 1 fall, 2 both, 3 none
//   cfg_filter_len      : glitch filter length (extra stable cycles)
//   cfg_holdoff         : cycles edges are ignored after an accept
//   cfg_clear           : clears ts_valid and the overflow statistics
//   rtc_sec, rtc_nsec   : running RTC time
//   ext_trigger         : accepted-trigger pulse
//   ts_valid/ts_ready   : timestamp handshake; ts_sec/ts_nsec hold the stamp
//   stat_level          : filtered pin level
//   stat_overflow       : sticky, a trigger arrived while a stamp was pending
//   stat_missed         : saturating count of dropped stamps
// ---------------------------------------------------------------------------
module axi_ts_ext_trig #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 8,
    parameter int MISS_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig_in,
    input  logic                cfg_enable,
    input  logic [1:0]          cfg_edge,
    input  logic [FILTER_W-1:0] cfg_filter_len,
    input  logic [31:0]         cfg_holdoff,
    input  logic                cfg_clear,
    input  logic [31:0]         rtc_sec,
    input  logic [31:0]         rtc_nsec,
    output logic                ext_trigger,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [31:0]         ts_sec,
    output logic [31:0]         ts_nsec,
    output logic                stat_level,
    output logic                stat_overflow,
    output logic [MISS_W-1:0]   stat_missed
);
    import axi_ts_pkg::*;

    logic w_filt;
    logic w_rise;
    logic w_fall;
    logic w_edge_hit;

    axi_ts_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_W    (FILTER_W)
    ) u_sync_filter (
        .clk            (clk),
        .rst            (rst),
        .trig_in        (trig_in),
        .cfg_filter_len (cfg_filter_len),
        .filt           (w_filt),
        .rise           (w_rise),
        .fall           (w_fall)
    );

    assign w_edge_hit = edge_select(cfg_edge, w_rise, w_fall);

    // ------------------------------------------------------------------
    // Acceptance state machine
    // ------------------------------------------------------------------
    ext_trig_state_e r_state;
    ext_trig_state_e w_state_next;
    logic [31:0]     r_hcnt;
    logic [31:0]     w_hcnt_next;
    logic            w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_enable) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (w_edge_hit) begin
                    w_accept = 1'b1;
                    // Holdoff is sampled here only; later register writes
                    // do not disturb a holdoff already running.
                    if (cfg_holdoff != 32'd0) begin
                        w_state_next = HOLDOFF;
                        w_hcnt_next  = cfg_holdoff - 32'd1;
                    end
                end
            end
            HOLDOFF: begin
                if (r_hcnt == 32'd0) begin
                    w_state_next = ARMED;
                end else begin
                    w_hcnt_next = r_hcnt - 32'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Disabling wins for the next state, but an edge seen while still
        // ARMED in this cycle has already been accepted above.
        if (!cfg_enable) begin
            w_state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Trigger pulse, timestamp capture and overflow accounting
    // ------------------------------------------------------------------
    logic              r_ext_trigger;
    logic              r_ts_valid;
    logic [31:0]       r_ts_sec;
    logic [31:0]       r_ts_nsec;
    logic              r_stat_overflow;
    logic [MISS_W-1:0] r_stat_missed;
    logic              w_ts_load;
    logic              w_ts_drop;

    // A clear frees the slot in the same cycle, so a coincident accept
    // stores its stamp instead of being counted as missed.
    assign w_ts_load = w_accept & (~r_ts_valid | ts_ready | cfg_clear);
    assign w_ts_drop = w_accept & r_ts_valid & ~ts_ready & ~cfg_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_trigger   <= 1'b0;
            r_ts_valid      <= 1'b0;
            r_ts_sec        <= '0;
            r_ts_nsec       <= '0;
            r_stat_overflow <= 1'b0;
            r_stat_missed   <= '0;
        end else begin
            r_ext_trigger <= w_accept;

            if (w_ts_load) begin
                r_ts_sec  <= rtc_sec;
                r_ts_nsec <= rtc_nsec;
            end

            if (w_ts_load) begin
                r_ts_valid <= 1'b1;
            end else if (cfg_clear || (r_ts_valid && ts_ready)) begin
                r_ts_valid <= 1'b0;
            end

            if (cfg_clear) begin
                r_stat_overflow <= 1'b0;
                r_stat_missed   <= '0;
            end else if (w_ts_drop) begin
                r_stat_overflow <= 1'b1;
                if (r_stat_missed != {MISS_W{1'b1}}) begin
                    r_stat_missed <= r_stat_missed + MISS_W'(1);
                end
            end
        end
    end

    assign ext_trigger   = r_ext_trigger;
    assign ts_valid      = r_ts_valid;
    assign ts_sec        = r_ts_sec;
    assign ts_nsec       = r_ts_nsec;
    assign stat_level    = w_filt;
    assign stat_overflow = r_stat_overflow;
    assign stat_missed   = r_stat_missed;

endmodule

// File: tb/tb_axi_ts_ext_trig.sv
// ---------------------------------------------------------------------------
// tb_axi_ts_ext_trig
// Directed bench for axi_ts_ext_trig: a table of pin pulses with hand-derived
// trigger expectations, then hand-written holdoff, overflow, enable and
// reset sequences.
// Timing reference: inputs change 1 ns after a rising edge ("tick"). A pin
// change made right after tick d is captured at tick d+1, and the accept
// pulse is visible after tick d + 1 + (SYNC + filter_len + 2).
// ---------------------------------------------------------------------------
module tb_axi_ts_ext_trig;
    import axi_ts_pkg::*;

    localparam int SYNC = 2;
    localparam int FW   = 8;
    localparam int MW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          trig_in;
    logic          cfg_enable;
    logic [1:0]    cfg_edge;
    logic [FW-1:0] cfg_filter_len;
    logic [31:0]   cfg_holdoff;
    logic          cfg_clear;
    logic [31:0]   rtc_sec;
    logic [31:0]   rtc_nsec;
    logic          ext_trigger;
    logic          ts_valid;
    logic          ts_ready;
    logic [31:0]   ts_sec;
    logic [31:0]   ts_nsec;
    logic          stat_level;
    logic          stat_overflow;
    logic [MW-1:0] stat_missed;

    axi_ts_ext_trig #(
        .SYNC_STAGES (SYNC),
        .FILTER_W    (FW),
        .MISS_W      (MW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trig_in        (trig_in),
        .cfg_enable     (cfg_enable),
        .cfg_edge       (cfg_edge),
        .cfg_filter_len (cfg_filter_len),
        .cfg_holdoff    (cfg_holdoff),
        .cfg_clear      (cfg_clear),
        .rtc_sec        (rtc_sec),
        .rtc_nsec       (rtc_nsec),
        .ext_trigger    (ext_trigger),
        .ts_valid       (ts_valid),
        .ts_ready       (ts_ready),
        .ts_sec         (ts_sec),
        .ts_nsec        (ts_nsec),
        .stat_level     (stat_level),
        .stat_overflow  (stat_overflow),
        .stat_missed    (stat_missed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        edge_sel_e esel;
        int        flen;
        int        width;      // cycles trig_in is held high
        bit        passes;     // high pulse survives the filter
        bit        exp_rise;   // rising edge produces a trigger
        bit        exp_fall;   // falling edge produces a trigger
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // One clock; the RTC follows a bench-owned counter so every stamp is known.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rtc_sec  = 32'(cyc);
        rtc_nsec = 32'(cyc * 3 + 1);
    endtask

    function automatic logic [31:0] nsec_of(input int c);
        return 32'(c * 3 + 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " ext_trigger"},   64'(ext_trigger),   64'd0);
        check({tag, " ts_valid"},      64'(ts_valid),      64'd0);
        check({tag, " ts_sec"},        64'(ts_sec),        64'd0);
        check({tag, " ts_nsec"},       64'(ts_nsec),       64'd0);
        check({tag, " stat_level"},    64'(stat_level),    64'd0);
        check({tag, " stat_overflow"}, 64'(stat_overflow), 64'd0);
        check({tag, " stat_missed"},   64'(stat_missed),   64'd0);
    endtask

    initial begin
        int  lat;
        int  fires;
        bit  e_fire;
        bit  e_lvl;
        int  first_stamp;

        vecs[0] = '{RISE, 0, 3, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{FALL, 0, 3, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{BOTH, 0, 3, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{NONE, 0, 3, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{RISE, 5, 5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{RISE, 5, 6, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{BOTH, 2, 3, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{BOTH, 3, 3, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{BOTH, 1, 1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{FALL, 4, 5, 1'b1, 1'b0, 1'b1};

        rst            = 1'b1;
        trig_in        = 1'b0;
        cfg_enable     = 1'b0;
        cfg_edge       = RISE;
        cfg_filter_len = '0;
        cfg_holdoff    = '0;
        cfg_clear      = 1'b0;
        ts_ready       = 1'b1;
        rtc_sec        = '0;
        rtc_nsec       = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check_all_zero("reset");
        rst        = 1'b0;
        cfg_enable = 1'b1;
        repeat (3) tick();
        $display("reset: outputs checked, enable asserted");

        // ---------------- table-driven pulses ----------------
        for (int v = 0; v < 10; v++) begin
            cfg_edge       = vecs[v].esel;
            cfg_filter_len = FW'(vecs[v].flen);
            lat            = SYNC + vecs[v].flen + 2;
            fires          = 0;
            trig_in        = 1'b1;
            for (int i = 1; i <= vecs[v].width + lat + 6; i++) begin
                tick();
                if (i == vecs[v].width) trig_in = 1'b0;
                e_fire = (vecs[v].exp_rise && i == 1 + lat) ||
                         (vecs[v].exp_fall && i == vecs[v].width + 1 + lat);
                e_lvl  = vecs[v].passes && (i >= 3 + vecs[v].flen) &&
                         (i < vecs[v].width + 3 + vecs[v].flen);
                check($sformatf("vec%0d t%0d ext_trigger", v, i), 64'(ext_trigger), 64'(e_fire));
                check($sformatf("vec%0d t%0d stat_level", v, i), 64'(stat_level), 64'(e_lvl));
                if (e_fire) begin
                    fires++;
                    check($sformatf("vec%0d ts_valid", v), 64'(ts_valid), 64'd1);
                    check($sformatf("vec%0d ts_sec", v), 64'(ts_sec), 64'(cyc - 1));
                    check($sformatf("vec%0d ts_nsec", v), 64'(ts_nsec), 64'(nsec_of(cyc - 1)));
                end
            end
            $display("vec %0d: edge=%0d flen=%0d width=%0d expected_fires=%0d",
                     v, vecs[v].esel, vecs[v].flen, vecs[v].width, fires);
        end

        // ---------------- holdoff = 10, both edges ----------------
        // First accept at t5 (A). Edges that would accept at A+6 and A+10
        // fall inside the holdoff; the one at A+11 is accepted.
        cfg_edge       = BOTH;
        cfg_filter_len = '0;
        cfg_holdoff    = 32'd10;
        trig_in        = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 5)  cfg_holdoff = 32'd0;   // must not shorten the running holdoff
            if (i == 6)  trig_in = 1'b0;
            if (i == 10) trig_in = 1'b1;
            if (i == 11) trig_in = 1'b0;
            e_fire = (i == 5) || (i == 16);
            check($sformatf("holdoff t%0d ext_trigger", i), 64'(ext_trigger), 64'(e_fire));
        end
        $display("holdoff: accepts expected at t5 and t16 only");

        // ---------------- overflow accounting ----------------
        cfg_edge    = RISE;
        ts_ready    = 1'b0;
        first_stamp = 0;
        trig_in     = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (i == 2 || i == 10 || i == 18) trig_in = 1'b0;
            if (i == 8 || i == 16)            trig_in = 1'b1;
            e_fire = (i == 5) || (i == 13) || (i == 21);
            check($sformatf("ovf t%0d ext_trigger", i), 64'(ext_trigger), 64'(e_fire));
            if (i == 5) first_stamp = cyc - 1;
        end
        check("ovf ts_valid",      64'(ts_valid),      64'd1);
        check("ovf ts_sec",        64'(ts_sec),        64'(first_stamp));
        check("ovf ts_nsec",       64'(ts_nsec),       64'(nsec_of(first_stamp)));
        check("ovf stat_overflow", 64'(stat_overflow), 64'd1);
        check("ovf stat_missed",   64'(stat_missed),   64'd2);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        check("clear ts_valid",      64'(ts_valid),      64'd0);
        check("clear stat_overflow", 64'(stat_overflow), 64'd0);
        check("clear stat_missed",   64'(stat_missed),   64'd0);
        $display("overflow: three accepts with ts_ready low, then clear");

        // ---------------- clear coinciding with an accept ----------------
        trig_in = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 2 || i == 10) trig_in = 1'b0;
            if (i == 8)            trig_in = 1'b1;
            if (i == 12)           cfg_clear = 1'b1;
            if (i == 13)           cfg_clear = 1'b0;
            e_fire = (i == 5) || (i == 13);
            check($sformatf("clracc t%0d ext_trigger", i), 64'(ext_trigger), 64'(e_fire));
            if (i == 13) begin
                check("clracc ts_valid",      64'(ts_valid),      64'd1);
                check("clracc ts_sec",        64'(ts_sec),        64'(cyc - 1));
                check("clracc stat_overflow", 64'(stat_overflow), 64'd0);
                check("clracc stat_missed",   64'(stat_missed),   64'd0);
            end
        end
        ts_ready = 1'b1;
        tick();
        check("handshake ts_valid", 64'(ts_valid), 64'd0);
        $display("clear+accept: new stamp kept, statistics cleared, handshake drains");

        // ---------------- enable gating ----------------
        cfg_enable = 1'b0;
        trig_in    = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 4) trig_in = 1'b0;
            if (i == 8) trig_in = 1'b1;
            check($sformatf("disabled t%0d ext_trigger", i), 64'(ext_trigger), 64'd0);
        end
        check("disabled stat_level", 64'(stat_level), 64'd1);
        cfg_enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("enable_high t%0d ext_trigger", i), 64'(ext_trigger), 64'd0);
        end
        trig_in = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 6) trig_in = 1'b1;
            check($sformatf("enable_edge t%0d ext_trigger", i), 64'(ext_trigger), 64'(i == 11));
        end
        $display("enable: no accepts while disabled or on enable, accept on new edge");

        // ---------------- async reset during holdoff ----------------
        cfg_holdoff = 32'd50;
        ts_ready    = 1'b0;
        trig_in     = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 6) trig_in = 1'b1;
            check($sformatf("prerst t%0d ext_trigger", i), 64'(ext_trigger), 64'(i == 11));
        end
        check("prerst ts_valid", 64'(ts_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        trig_in = 1'b0;
        tick();
        check_all_zero("held_rst");
        rst         = 1'b0;
        cfg_holdoff = 32'd0;
        ts_ready    = 1'b1;
        repeat (3) tick();
        trig_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("postrst t%0d ext_trigger", i), 64'(ext_trigger), 64'(i == 5));
            if (i == 5) begin
                check("postrst ts_valid", 64'(ts_valid), 64'd1);
                check("postrst ts_sec",   64'(ts_sec),   64'(cyc - 1));
            end
        end
        $display("reset: async clear in holdoff, first post-reset trigger at nominal latency");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
